// File: rtl/latch_seq_pkg.sv
// latch_seq_pkg: op encoding, FSM state type and op helpers for latch_sequencer
package latch_seq_pkg;
  localparam logic [2:0] OP_WR  = 3'd0;
  localparam logic [2:0] OP_WR3 = 3'd1;
  localparam logic [2:0] OP_RD1 = 3'd2;
  localparam logic [2:0] OP_RD2 = 3'd3;
  localparam logic [2:0] OP_RD3 = 3'd4;
  typedef enum logic [2:0] {IDLE, GRANT, PULSE, RECOVER, READ, DONE} state_t;
  function automatic logic op_is_write(input logic [2:0] op);
    return op == OP_WR || op == OP_WR3;
  endfunction
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_RD3;
  endfunction
endpackage

// File: rtl/latch_seq_arb2.sv
// latch_seq_arb2: two-way arbiter, fixed A priority or round robin when
// LATCH_SEQ_ROUND_ROBIN_EN is defined
module latch_seq_arb2 (
`ifdef LATCH_SEQ_ROUND_ROBIN_EN
  input  logic clk,
  input  logic reset,
  input  logic take,
`endif
  input  logic req_a,
  input  logic req_b,
  output logic gnt_b
);
`ifdef LATCH_SEQ_ROUND_ROBIN_EN
  logic ptr_b;
  // ptr_b set means B is favoured on the next contention
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr_b <= 1'b0;
    else if (take) ptr_b <= ~gnt_b;
  assign gnt_b = req_b & (~req_a | ptr_b);
`else
  assign gnt_b = req_b & ~req_a;
`endif
endmodule

// File: rtl/latch_sequencer.sv
// latch_sequencer: arbitrates two requesters and sequences latch/latch3 strobes
// and output enables; LATCH_SEQ_ROUND_ROBIN_EN selects round-robin arbitration
module latch_sequencer
  import latch_seq_pkg::*;
#(
  parameter int LATCH_PW    = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [2:0] op_a,
  input  logic [2:0] op_b,
  output logic       sel,
  output logic       latch,
  output logic       latch3,
  output logic       oe1,
  output logic       oe2,
  output logic       oe3,
  output logic       ack_a,
  output logic       ack_b,
  output logic       err,
  output logic       busy
);
  localparam logic [2:0] PW_LAST   = 3'(LATCH_PW - 1);
  localparam logic [2:0] HOLD_LAST = 3'(HOLD_CYCLES - 1);
  state_t state, state_n;
  logic [2:0] op_q, op_n, cnt, cnt_n;
  logic sel_n, gnt_b, ack_n;
  latch_seq_arb2 u_arb (
`ifdef LATCH_SEQ_ROUND_ROBIN_EN
    .clk   (clk),
    .reset (reset),
    .take  (state == IDLE && (req_a || req_b)),
`endif
    .req_a (req_a),
    .req_b (req_b),
    .gnt_b (gnt_b)
  );
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    op_n    = op_q;
    case (state)
      IDLE: if (req_a || req_b) begin
        state_n = GRANT;
        sel_n   = gnt_b;
        op_n    = gnt_b ? op_b : op_a;
      end
      GRANT: begin
        cnt_n   = 3'd0;
        state_n = op_is_write(op_q) ? PULSE : op_legal(op_q) ? READ : DONE;
      end
      PULSE: begin
        cnt_n   = cnt + 3'd1;
        state_n = cnt == PW_LAST ? RECOVER : PULSE;
      end
      RECOVER: state_n = DONE;
      READ: begin
        cnt_n   = cnt + 3'd1;
        state_n = cnt == HOLD_LAST ? IDLE : READ;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are decoded from the next state so every output is a flop
  assign ack_n = state_n == DONE || (state_n == READ && cnt_n == HOLD_LAST);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      op_q   <= OP_WR;
      cnt    <= 3'd0;
      sel    <= 1'b0;
      latch  <= 1'b0;
      latch3 <= 1'b0;
      oe1    <= 1'b0;
      oe2    <= 1'b0;
      oe3    <= 1'b0;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      cnt    <= cnt_n;
      sel    <= sel_n;
      latch  <= state_n == PULSE && op_n == OP_WR;
      latch3 <= state_n == PULSE && op_n == OP_WR3;
      oe1    <= state_n == READ && op_n == OP_RD1;
      oe2    <= state_n == READ && op_n == OP_RD2;
      oe3    <= state_n == READ && op_n == OP_RD3;
      ack_a  <= ack_n && !sel_n;
      ack_b  <= ack_n && sel_n;
      err    <= state_n == DONE && !op_legal(op_n);
      busy   <= state_n != IDLE;
    end
endmodule

// File: tb/tb_latch_sequencer.sv
// tb_latch_sequencer: two parameterisations checked cycle by cycle against a
// transaction-schedule model; honours LATCH_SEQ_ROUND_ROBIN_EN
module tb_latch_sequencer;
  typedef struct packed {
    logic sel, latch, latch3, oe1, oe2, oe3, ack_a, ack_b, err, busy;
  } ov_t;
`ifdef LATCH_SEQ_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, req_a = 1'b0, req_b = 1'b0;
  logic [2:0] op_a = 3'd0, op_b = 3'd0;
  ov_t o [2];
  int n_chk = 0, n_fail = 0, cyc = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic sel, latch, latch3, oe1, oe2, oe3, ack_a, ack_b, err, busy;
    latch_sequencer #(.LATCH_PW(g == 0 ? 1 : 3), .HOLD_CYCLES(g == 0 ? 2 : 3)) u_dut (
      .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
      .sel(sel), .latch(latch), .latch3(latch3), .oe1(oe1), .oe2(oe2), .oe3(oe3),
      .ack_a(ack_a), .ack_b(ack_b), .err(err), .busy(busy));
    assign o[g] = {sel, latch, latch3, oe1, oe2, oe3, ack_a, ack_b, err, busy};
  end
  // model: on a grant the whole transaction's per-cycle outputs are scheduled
  ov_t sched [2][16];
  int len [2], pos [2];
  logic last_b [2], sel_m [2];
  task automatic chk(input string tag, input ov_t obs, input ov_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b (sel,latch,latch3,oe1,oe2,oe3,ack_a,ack_b,err,busy)", tag, obs, exp);
    end
  endtask
  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask
  task automatic model_reset(input int i);
    len[i] = 0; pos[i] = 0; last_b[i] = 1'b1; sel_m[i] = 1'b0;
  endtask
  task automatic push(input int i, input ov_t v);
    sched[i][len[i]] = v;
    len[i]++;
  endtask
  task automatic model_edge(input int i, output ov_t e);
    ov_t v, w;
    logic wb;
    logic [2:0] op;
    int pw, hold;
    pw = i == 0 ? 1 : 3;
    hold = i == 0 ? 2 : 3;
    if (pos[i] < len[i]) begin
      e = sched[i][pos[i]];
      pos[i]++;
      return;
    end
    v = '0;
    v.sel = sel_m[i];
    if (!(req_a || req_b)) begin
      e = v;
      return;
    end
    wb = req_b && (!req_a || (RR && !last_b[i]));
    last_b[i] = wb;
    sel_m[i] = wb;
    op = wb ? op_b : op_a;
    len[i] = 0;
    v.sel = wb;
    v.busy = 1'b1;
    push(i, v);
    w = v;
    if (wb) w.ack_b = 1'b1; else w.ack_a = 1'b1;
    if (op <= 3'd1) begin
      for (int k = 0; k < pw; k++) begin
        ov_t s = v;
        s.latch = op == 3'd0;
        s.latch3 = op == 3'd1;
        push(i, s);
      end
      push(i, v);
      push(i, w);
    end else if (op <= 3'd4) begin
      for (int k = 0; k < hold; k++) begin
        ov_t s = (k == hold - 1) ? w : v;
        s.oe1 = op == 3'd2;
        s.oe2 = op == 3'd3;
        s.oe3 = op == 3'd4;
        push(i, s);
      end
    end else begin
      w.err = 1'b1;
      push(i, w);
    end
    v = '0;
    v.sel = wb;
    push(i, v);
    e = sched[i][0];
    pos[i] = 1;
  endtask
  task automatic tick();
    ov_t e [2];
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      if (reset) begin model_reset(i); e[i] = '0; end
      else model_edge(i, e[i]);
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("cyc%0d_dut%0d", cyc, i), o[i], e[i]);
    cyc++;
  endtask
  task automatic async_reset();
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      chk($sformatf("async_reset_dut%0d", i), o[i], '0);
    end
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic drain(input int n);
    req_a = 1'b0;
    req_b = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic run_req(input string tag, input logic b, input logic [2:0] op);
    logic got = 1'b0;
    if (b) begin req_b = 1'b1; op_b = op; end
    else begin req_a = 1'b1; op_a = op; end
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = b ? o[0].ack_b : o[0].ack_a;
    end
    chk_b({tag, "_acked"}, got, 1'b1);
    drain(12);
  endtask
  initial begin
    int na, nb;
    #2 async_reset();
    run_req("a_wr", 1'b0, 3'd0);
    run_req("b_rd3", 1'b1, 3'd4);
    run_req("a_rd1", 1'b0, 3'd2);
    run_req("b_rd2", 1'b1, 3'd3);
    run_req("a_illegal6", 1'b0, 3'd6);
    run_req("b_wr3", 1'b1, 3'd1);
    na = 0;
    nb = 0;
    req_a = 1'b1; req_b = 1'b1; op_a = 3'd1; op_b = 3'd1;
    for (int k = 0; k < 40; k++) begin
      tick();
      na += int'(o[0].ack_a);
      nb += int'(o[0].ack_b);
    end
    chk_b("contend_a_acked", na > 0, 1'b1);
    chk_b("contend_b_acked", nb > 0, RR);
    drain(12);
    req_a = 1'b1; op_a = 3'd0;
    tick();
    req_a = 1'b0;
    tick();
    async_reset();
    run_req("a_wr_after_reset", 1'b0, 3'd0);
    req_a = 1'b1; op_a = 3'd0;
    for (int k = 0; k < 40; k++) tick();
    drain(12);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) req_a = ~req_a;
      if ($urandom_range(0, 3) == 0) req_b = ~req_b;
      op_a = 3'($urandom_range(0, 7));
      op_b = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) async_reset();
      else tick();
    end
    drain(12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
